// File: rtl/uart_tx_bridge_pkg.sv
// Shared types and helpers for the UART transmit bridge.
// The optional even-parity frame bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Clocks per UART bit time (integer division, truncating).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Even parity over one data byte: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_bridge_if.sv
// Byte write handshake between the processor serial port and the bridge.
interface uart_tx_bridge_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 wren_in;
    logic                 ready_out;

    modport master (output data_in, output wren_in, input ready_out);
    modport slave  (input data_in, input wren_in, output ready_out);

endinterface

// File: rtl/uart_tx_bridge_sync_fifo.sv
// Small synchronous FIFO: registered storage and occupancy, combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_V);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents need no reset since occupancy guards every read.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_bridge.sv
// UART transmit bridge: buffers processor bytes and sends them as 8N1 frames
// (8E1 when UART_TX_PARITY_EN is defined). ready_out gives back-pressure.
module uart_tx_bridge
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_bridge_if.slave               bus,
    output logic                          tx_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_out,
    output logic                          overflow_out
);
    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            state_r, state_s;
    logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic [2:0]           bit_idx_r, bit_idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 tx_r, tx_s;
    logic                 busy_r;
    logic                 overflow_r;
    logic                 push_s, pop_s, full_s, empty_s;
    logic [DATA_BITS-1:0] head_s;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r, parity_s;
`endif

    assign push_s        = bus.wren_in && !full_s;
    assign bus.ready_out = !full_s;
    assign tx_out        = tx_r;
    assign busy_out      = busy_r;
    assign overflow_out  = overflow_r;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.data_in),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_out)
    );

    // Next-state, baud counting and next line level; tx is computed for the
    // state being entered so the registered line changes on the same edge.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = head_s;
`ifdef UART_TX_PARITY_EN
                    parity_s  = even_parity(head_s);
`endif
                    bit_cnt_s = {CNT_W{1'b0}};
                    state_s   = START;
                    tx_s      = 1'b0;
                end else begin
                    tx_s      = 1'b1;
                end
            end
            START: begin
                if (bit_cnt_r == CNT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                    tx_s      = shift_r[0];
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt_r == CNT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
                        tx_s    = parity_r;
`else
                        state_s = STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = shift_r >> 1;
                        tx_s      = shift_r[1];
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_cnt_r == CNT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    state_s   = STOP;
                    tx_s      = 1'b1;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_cnt_r == CNT_LAST) begin
                    bit_cnt_s = {CNT_W{1'b0}};
                    state_s   = IDLE;
                    tx_s      = 1'b1;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                bit_cnt_s = {CNT_W{1'b0}};
                tx_s      = 1'b1;
            end
        endcase
    end

    // FSM, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != IDLE);
            overflow_r <= overflow_r | (bus.wren_in & full_s);
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

endmodule
